// File: rtl/byte_lane_sequencer_pkg.sv
// Shared PHY transmit constants: width codes, sequencer state encoding,
// lane counts and the width-select decode used at word acceptance.
package byte_lane_sequencer_pkg;

  // PCLK width-select codes
  localparam logic [1:0] W32  = 2'b00;
  localparam logic [1:0] W16  = 2'b01;
  localparam logic [1:0] W8   = 2'b10;
  localparam logic [1:0] WINV = 2'b11;

  // Active lane counts; zero marks an invalid width selection
  localparam logic [2:0] LANES_4 = 3'd4;
  localparam logic [2:0] LANES_2 = 3'd2;
  localparam logic [2:0] LANES_1 = 3'd1;
  localparam logic [2:0] LANES_0 = 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DROP = 2'd2
  } state_t;

  // MODO overrides PCLK and forces the full 32-bit word onto the lanes
  function automatic logic [2:0] decode_lanes(input logic [1:0] pclk, input logic modo);
    logic [2:0] n;
    n = LANES_0;
    if (modo) begin
      n = LANES_4;
    end else begin
      case (pclk)
        W32:     n = LANES_4;
        W16:     n = LANES_2;
        W8:      n = LANES_1;
        WINV:    n = LANES_0;
        default: n = LANES_0;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/byte_lane_sequencer_lane_mux.sv
// Combinational byte picker: maps the lane counter onto a byte position of the
// latched word, walking down from the highest active lane when MSB_FIRST=1.
module byte_lane_sequencer_lane_mux
  import byte_lane_sequencer_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [IN_W-1:0] word,
  input  logic [2:0]      lanes,
  input  logic [1:0]      idx,
  output logic [7:0]      lane_byte
);

  logic [2:0] pos;

  // Translate the transmit-order index into a byte position and select it
  always_comb begin
    pos       = 3'd0;
    lane_byte = 8'h00;
    if (MSB_FIRST) begin
      pos = lanes - 3'd1 - {1'b0, idx};
    end else begin
      pos = {1'b0, idx};
    end
    case (pos)
      3'd0:    lane_byte = word[7:0];
      3'd1:    lane_byte = word[15:8];
      3'd2:    lane_byte = word[23:16];
      3'd3:    lane_byte = word[31:24];
      default: lane_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/byte_lane_sequencer.sv
// Transmit-side 32-to-8 sequencer: accepts a parallel word, latches its lane
// count from PCLK/MODO and streams the active bytes one per out handshake.
//
// Handshakes: a word moves when in_valid && in_ready at a rising clk edge; a
// byte moves when out_valid && out_ready at a rising clk edge. out_valid and
// out_8 never change while out_valid=1 and out_ready=0. in_ready is high in
// IDLE and on the last byte of a word when out_ready=1, so words can follow
// each other with no bubble.
module byte_lane_sequencer
  import byte_lane_sequencer_pkg::*;
#(
  parameter int         IN_W      = 32,
  parameter logic [7:0] IDLE_BYTE = 8'h00,
  parameter bit         MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic [1:0]      PCLK,
  input  logic            MODO,
  input  logic [IN_W-1:0] in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [7:0]      out_8,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            err_mode
);

  state_t          state;
  state_t          state_next;
  logic [IN_W-1:0] word_q;
  logic [2:0]      lanes_q;
  logic [1:0]      idx_q;
  logic            last_lane;
  logic            accept;
  logic [2:0]      acc_lanes;
  logic            acc_valid;
  logic [7:0]      lane_byte;

  // Mode decode and handshake qualifiers for the word on the input side
  always_comb begin
    acc_lanes = decode_lanes(PCLK, MODO);
    acc_valid = (acc_lanes != LANES_0);
    last_lane = ({1'b0, idx_q} == (lanes_q - 3'd1));
    accept    = in_valid && in_ready;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Word, lane count and lane counter; all frozen while the byte is stalled
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      word_q  <= '0;
      lanes_q <= LANES_0;
      idx_q   <= 2'd0;
    end else if (accept && acc_valid) begin
      word_q  <= in;
      lanes_q <= acc_lanes;
      idx_q   <= 2'd0;
    end else if ((state == SEND) && out_ready && !last_lane) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = acc_valid ? SEND : DROP;
      end
      SEND: begin
        if (out_ready && last_lane) begin
          if (accept) state_next = acc_valid ? SEND : DROP;
          else        state_next = IDLE;
        end
      end
      DROP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  byte_lane_sequencer_lane_mux #(
    .IN_W      (IN_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_lane_mux (
    .word      (word_q),
    .lanes     (lanes_q),
    .idx       (idx_q),
    .lane_byte (lane_byte)
  );

  // Outputs decoded from the registered state and lane selection
  always_comb begin
    out_valid = (state == SEND);
    out_8     = (state == SEND) ? lane_byte : IDLE_BYTE;
    err_mode  = (state == DROP);
    busy      = (state != IDLE);
    in_ready  = (state == IDLE) || ((state == SEND) && last_lane && out_ready);
  end

endmodule

// File: tb/tb_byte_lane_sequencer.sv
// Bench for byte_lane_sequencer: directed scenarios plus randomized traffic,
// all checked against a byte-queue model of the width-conversion rules.
module tb_byte_lane_sequencer;

  logic        clk;
  logic        reset_L;
  logic [1:0]  PCLK;
  logic        MODO;
  logic [31:0] in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_8;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        err_mode;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       drop_now = 1'b0;
  logic       bp_rand  = 1'b0;

  byte_lane_sequencer dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .PCLK      (PCLK),
    .MODO      (MODO),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_8     (out_8),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .err_mode  (err_mode)
  );

  // clock / reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // number of active lanes for a mode, 0 when the mode is invalid
  function automatic int model_lanes(input logic [1:0] p, input logic m);
    if (m) return 4;
    if (p == 2'd0) return 4;
    if (p == 2'd1) return 2;
    if (p == 2'd2) return 1;
    return 0;
  endfunction

  // random downstream backpressure when enabled
  always @(posedge clk) begin
    #1;
    if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  // scoreboard: expected byte stream as a queue, sampled on the falling edge
  always @(negedge clk) begin
    logic exp_valid;
    logic exp_ready;
    logic next_drop;
    int   n;
    logic [7:0] b;
    if (!reset_L) begin
      exp_q.delete();
      drop_now = 1'b0;
    end else begin
      exp_valid = (exp_q.size() != 0);
      exp_ready = !drop_now && ((exp_q.size() == 0) || ((exp_q.size() == 1) && out_ready));
      checks++;
      if (out_valid !== exp_valid) begin
        errors++;
        $display("FAIL sb_out_valid t=%0t got %b want %b", $time, out_valid, exp_valid);
      end
      checks++;
      if (exp_valid) begin
        if (out_8 !== exp_q[0]) begin
          errors++;
          $display("FAIL sb_out_8 t=%0t got %h want %h", $time, out_8, exp_q[0]);
        end
      end else if (out_8 !== 8'h00) begin
        errors++;
        $display("FAIL sb_idle_byte t=%0t got %h want 00", $time, out_8);
      end
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("FAIL sb_in_ready t=%0t got %b want %b", $time, in_ready, exp_ready);
      end
      checks++;
      if (err_mode !== drop_now) begin
        errors++;
        $display("FAIL sb_err_mode t=%0t got %b want %b", $time, err_mode, drop_now);
      end
      checks++;
      if (busy !== (exp_valid || drop_now)) begin
        errors++;
        $display("FAIL sb_busy t=%0t got %b want %b", $time, busy, exp_valid || drop_now);
      end
      if (exp_valid && out_ready) void'(exp_q.pop_front());
      next_drop = 1'b0;
      if (in_valid && exp_ready) begin
        n = model_lanes(PCLK, MODO);
        if (n == 0) next_drop = 1'b1;
        for (int i = 0; i < n; i++) begin
          b = 8'((in >> (8 * (n - 1 - i))) & 32'hFF);
          exp_q.push_back(b);
        end
      end
      drop_now = next_drop;
    end
  end

  // driver: offer a word and hold it until accepted; returns just after the accept edge
  task automatic send_word(input logic [31:0] w, input logic [1:0] p, input logic m);
    logic acc;
    in       = w;
    PCLK     = p;
    MODO     = m;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout word %h got no in_ready want accept", w);
    end
  endtask

  // wait for the model and DUT to go idle, bounded
  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !drop_now && (busy === 1'b0);
      @(posedge clk);
      #1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout got busy=%b queue=%0d want idle", busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_L   = 1'b0;
    in_valid  = 1'b1;
    in        = $urandom;
    PCLK      = 2'b00;
    MODO      = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_8 !== 8'h00 || err_mode !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_state got v=%b d=%h e=%b b=%b want 0 00 0 0", out_valid, out_8, err_mode, busy);
      end
      if (i == 2) begin
        reset_L  = 1'b1;
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || err_mode !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got in_ready=%b err=%b want 1 0", in_ready, err_mode);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_32bit();
    logic [7:0] exp_b[4];
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4;
    out_ready = 1'b1;
    send_word(32'hA1B2C3D4, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_8 !== exp_b[i]) begin
        errors++;
        $display("FAIL w32_byte%0d got v=%b %h want 1 %h", i, out_valid, out_8, exp_b[i]);
      end
      if (i == 3) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL w32_last_ready got %b want 1", in_ready);
        end
      end
      @(posedge clk);
      #1;
    end
    wait_drain();
  endtask

  task automatic test_modes();
    logic [1:0] mp[3];
    logic       mm[3];
    int         mn[3];
    logic [7:0] exp_b[3][4];
    mp[0] = 2'b01; mm[0] = 1'b0; mn[0] = 2;
    exp_b[0][0] = 8'h33; exp_b[0][1] = 8'h44; exp_b[0][2] = 8'h00; exp_b[0][3] = 8'h00;
    mp[1] = 2'b10; mm[1] = 1'b0; mn[1] = 1;
    exp_b[1][0] = 8'h44; exp_b[1][1] = 8'h00; exp_b[1][2] = 8'h00; exp_b[1][3] = 8'h00;
    mp[2] = 2'b10; mm[2] = 1'b1; mn[2] = 4;
    exp_b[2][0] = 8'h11; exp_b[2][1] = 8'h22; exp_b[2][2] = 8'h33; exp_b[2][3] = 8'h44;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      send_word(32'h11223344, mp[c], mm[c]);
      for (int i = 0; i < mn[c]; i++) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_8 !== exp_b[c][i]) begin
          errors++;
          $display("FAIL mode%0d_byte%0d got v=%b %h want 1 %h", c, i, out_valid, out_8, exp_b[c][i]);
        end
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mode%0d_extra_byte got v=%b %h want 0", c, out_valid, out_8);
      end
      @(posedge clk);
      #1;
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [7:0] tail[3];
    tail[0] = 8'hFE; tail[1] = 8'hBA; tail[2] = 8'hBE;
    out_ready = 1'b1;
    send_word(32'hCAFEBABE, 2'b00, 1'b0);
    PCLK = 2'b10;
    in   = $urandom;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_8 !== 8'hCA) begin
      errors++;
      $display("FAIL bp_first got v=%b %h want 1 ca", out_valid, out_8);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_8 !== 8'hFE) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b %h want 1 fe", i, out_valid, out_8);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_8 !== tail[i]) begin
        errors++;
        $display("FAIL bp_tail%0d got v=%b %h want 1 %h", i, out_valid, out_8, tail[i]);
      end
      @(posedge clk);
      #1;
    end
    wait_drain();
  endtask

  task automatic test_invalid();
    int err_cnt;
    int val_cnt;
    out_ready = 1'b1;
    send_word($urandom, 2'b11, 1'b0);
    err_cnt = 0;
    val_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (err_mode === 1'b1) err_cnt++;
      if (out_valid === 1'b1) val_cnt++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (err_cnt != 1 || val_cnt != 0) begin
      errors++;
      $display("FAIL invalid_pulse got err_cycles=%0d valid_cycles=%0d want 1 0", err_cnt, val_cnt);
    end
    send_word(32'h000000EE, 2'b10, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_8 !== 8'hEE) begin
      errors++;
      $display("FAIL invalid_recover got v=%b %h want 1 ee", out_valid, out_8);
    end
    @(posedge clk);
    #1;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[4];
    exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
    out_ready = 1'b1;
    send_word(32'h0000AABB, 2'b01, 1'b0);
    in       = 32'h0000CCDD;
    PCLK     = 2'b01;
    MODO     = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_8 !== exp_b[i]) begin
        errors++;
        $display("FAIL b2b_byte%0d got v=%b %h want 1 %h", i, out_valid, out_8, exp_b[i]);
      end
      if (i < 2) begin
        checks++;
        if (in_ready !== (i == 1)) begin
          errors++;
          $display("FAIL b2b_ready%0d got %b want %b", i, in_ready, (i == 1));
        end
      end
      @(posedge clk);
      #1;
      if (i == 1) in_valid = 1'b0;
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    int          seen;
    w = $urandom;
    out_ready = 1'b1;
    send_word(w, 2'b00, 1'b0);
    @(negedge clk);
    checks++;
    if (out_8 !== w[31:24]) begin
      errors++;
      $display("FAIL rstmid_byte0 got %h want %h", out_8, w[31:24]);
    end
    @(posedge clk);
    #1;
    reset_L = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_8 !== w[23:16]) begin
      errors++;
      $display("FAIL rstmid_byte1 got v=%b %h want 1 %h", out_valid, out_8, w[23:16]);
    end
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_cleared got v=%b busy=%b want 0 0", out_valid, busy);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rstmid_leftover got %0d bytes want 0", seen);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [1:0] p;
    bp_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      p = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      send_word($urandom, p, ($urandom_range(0, 4) == 0));
      PCLK = 2'($urandom_range(0, 3));
      MODO = 1'($urandom_range(0, 1));
      in   = $urandom;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    bp_rand   = 1'b0;
    out_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    reset_L   = 1'b0;
    PCLK      = 2'b00;
    MODO      = 1'b0;
    in        = 32'h0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_32bit();
    test_modes();
    test_backpressure();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue got %0d pending bytes want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
